l2_resp_multi: RTL and testbench
================================

Name: l2_resp_multi

Overview:
- Parametrised layer-2 response collector for the SPI command path.
- Armed by layer 3 (`l3_en`). Waits a fixed turnaround, hunts for a start byte, then collects a programmable 1..MAX_BYTES response.
- Optionally polls busy after the response. Applies internal timeouts, then reports done or error with status words `sw0`/`sw1`.
- Successor to the single-byte responder: adds multi-byte capture, busy polling, a programmable timeout and error codes.

Parameters:
MAX_BYTES, 5, maximum response length in bytes (1..7)
TMO_W, 8, width of the timeout counter and of `tmo_limit`
PRE_WAIT, 2, turnaround cycles between arm and first `resp_rdy` (>=1)
HOLD_CYC, 8, settle cycles after the last accepted byte before done/err (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising `clk`
pin_l2_clr  in  1  synchronous soft clear of the FSM
l3_en  in  1  arm pulse from layer 3
l3_cmd_done  in  1  layer-3 acknowledge that releases DONE/ERR
resp_len  in  3  expected byte count, latched at arm
busy_chk  in  1  enable busy polling after the response, latched at arm
tmo_limit  in  TMO_W  timeout in cycles (0 = disabled), latched at arm
resp  in  8  response byte
resp_vld  in  1  `resp` valid
resp_rdy  out  1  block accepts `resp`
resp_data  out  8*MAX_BYTES  captured bytes; byte i at [8i+7:8i]; byte 0 is the start byte
resp_cnt  out  3  bytes captured so far
resp_done  out  1  response complete, no error
resp_err  out  1  response failed
err_code  out  2  00 none, 01 start timeout, 10 busy timeout, 11 status error
sw0  out  8  {err_code, 3'b000, resp_cnt}
sw1  out  8  {b0[7:6], b0[5:4] | {2{resp_err}}, b0[3:0]}, where b0 = resp_data[7:0]

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all registers:
  - state=IDLE; resp_data, resp_cnt, err_code, counters and latched config all 0.
  - resp_rdy, resp_done and resp_err are 0.
- Outputs are decoded from state only:
  - resp_rdy=1 in START, COLLECT, BUSY.
  - resp_done=1 in DONE.
  - resp_err=1 in ERR.
- A transfer is a cycle with resp_vld & resp_rdy.
- pin_l2_clr has priority over everything except reset:
  - Next state is IDLE; counters and err_code clear.
  - resp_data and resp_cnt are retained.
  - Simultaneous pin_l2_clr and l3_en results in IDLE with no arm.
- Length latch: resp_len=0 is latched as 1; resp_len>MAX_BYTES is latched as MAX_BYTES.
- FSM states: IDLE, WAIT, START, COLLECT, BUSY, HOLD, DONE, ERR.
- IDLE:
  - On l3_en: latch config; clear resp_data, resp_cnt, err_code and the timeout counter; go to WAIT.
  - l3_en is ignored in every other state.
- WAIT: stay exactly PRE_WAIT cycles, then go to START. For l3_en at edge t, resp_rdy is first 1 in cycle t+1+PRE_WAIT.
- START:
  - A transfer with resp[7]=1 is a filler byte: discarded and not counted.
  - A transfer with resp[7]=0 stores byte 0 and sets resp_cnt=1, then goes to:
    - COLLECT if latched length > 1;
    - else BUSY if busy_chk;
    - else HOLD.
  - The timeout counter increments every START cycle without a start byte.
  - When tmo_limit≠0 and counter==tmo_limit, go to ERR with err_code=01.
  - A start byte in the same cycle as the limit wins.
- COLLECT:
  - Each transfer stores a byte at index resp_cnt and increments resp_cnt. There is no timeout here.
  - The transfer that makes resp_cnt equal the latched length goes to BUSY if busy_chk, else HOLD.
- BUSY:
  - Entered with the timeout counter cleared.
  - Transfers of 8'h00 mean busy: discarded, not stored.
  - The first nonzero transfer releases to HOLD.
  - Same timeout rule as START; expiry goes to ERR with err_code=10. A release in the limit cycle wins.
- HOLD:
  - Hold counter cleared on entry; count HOLD_CYC cycles.
  - Then go to ERR with err_code=11 if b0[6:1]≠0, else DONE.
- DONE/ERR: hold until l3_cmd_done, then go to IDLE. resp_data, resp_cnt and err_code are retained until the next arm.
- Reset or pin_l2_clr mid-collection aborts; no partial done/err pulse is produced.

Test Plan:
- Basic: resp_len=1, busy_chk=0, tmo_limit=20. l3_en at cycle 0 -> resp_rdy first 1 in cycle 3. Send FF, FF, 01 -> resp_data[7:0]=01; DONE 8 cycles after the 01 transfer; sw1=01; sw0=01; hold DONE until l3_cmd_done, then IDLE.
- Multi-byte: resp_len=5, bytes 00, AA, BB, CC, DD with resp_vld gaps -> resp_cnt=5, resp_data=DDCCBBAA00, resp_done=1, sw0=05.
- Start timeout: tmo_limit=4, only FF sent -> ERR after 4 START cycles, err_code=01, sw1=30, sw0=40.
- Busy: busy_chk=1, tmo_limit=10, start 00, then 00 ×3, then FF -> HOLD, then DONE. Repeat with 00 for 10 cycles -> ERR, err_code=10.
- Status error: start byte 04 -> ERR, err_code=11, sw1=34, sw0=C1.
- Clear/clamp: pin_l2_clr in COLLECT -> IDLE next cycle with done=err=0; pin_l2_clr with l3_en -> stays IDLE; resp_len=7 with MAX_BYTES=5 -> exactly 5 bytes captured.

Source files
------------

// File: rtl/l2_resp_multi.sv
// Layer-2 response collector for the SPI command path.
// Armed by layer 3, waits a fixed turnaround, hunts for a start byte (bit 7
// clear), captures a programmable number of bytes, optionally polls busy,
// then reports done or error with status words.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   pin_l2_clr            soft clear of the FSM (data/count retained)
//   l3_en, l3_cmd_done    arm pulse / release of DONE or ERR
//   resp_len, busy_chk,   per-transfer config, latched at arm
//   tmo_limit
//   resp, resp_vld,       response byte stream handshake
//   resp_rdy
//   resp_data, resp_cnt   captured bytes and byte count
//   resp_done, resp_err,  completion flags and error code
//   err_code
//   sw0, sw1              packed status words
module l2_resp_multi #(
   parameter int unsigned MAX_BYTES = 5,
   parameter int unsigned TMO_W     = 8,
   parameter int unsigned PRE_WAIT  = 2,
   parameter int unsigned HOLD_CYC  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pin_l2_clr,
   input  logic                   l3_en,
   input  logic                   l3_cmd_done,
   input  logic [2:0]             resp_len,
   input  logic                   busy_chk,
   input  logic [TMO_W-1:0]       tmo_limit,
   input  logic [7:0]             resp,
   input  logic                   resp_vld,
   output logic                   resp_rdy,
   output logic [8*MAX_BYTES-1:0] resp_data,
   output logic [2:0]             resp_cnt,
   output logic                   resp_done,
   output logic                   resp_err,
   output logic [1:0]             err_code,
   output logic [7:0]             sw0,
   output logic [7:0]             sw1
);

   localparam int unsigned DATA_W  = 8 * MAX_BYTES;
   localparam int unsigned CYC_MAX = (PRE_WAIT > HOLD_CYC) ? PRE_WAIT : HOLD_CYC;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_START = 2'b01;
   localparam logic [1:0] ERR_BUSY  = 2'b10;
   localparam logic [1:0] ERR_STAT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_START, S_COLLECT, S_BUSY, S_HOLD, S_DONE, S_ERR
   } state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [1:0]         code_q, code_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [2:0]         len_q, len_d;
   logic               busy_q, busy_d;
   logic [TMO_W-1:0]   limit_q, limit_d;
   logic               rdy_q, done_q, err_q;
   logic [7:0]         sw0_q, sw1_q;

   logic               xfer;
   logic [TMO_W-1:0]   tmo_inc;
   logic               tmo_hit;
   logic [2:0]         len_clamp;
   state_e             after_data;

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      tmo_d   = tmo_q;
      cyc_d   = cyc_q;
      len_d   = len_q;
      busy_d  = busy_q;
      limit_d = limit_q;

      xfer       = resp_vld & rdy_q;
      tmo_inc    = TMO_W'(tmo_q + 1'b1);
      // limit is compared against the count including the current cycle
      tmo_hit    = (limit_q != '0) && (tmo_inc == limit_q);
      after_data = busy_q ? S_BUSY : S_HOLD;

      if (resp_len == 3'd0) begin
         len_clamp = 3'd1;
      end else if (resp_len > 3'(MAX_BYTES)) begin
         len_clamp = 3'(MAX_BYTES);
      end else begin
         len_clamp = resp_len;
      end

      case (state_q)
         S_IDLE: begin
            if (l3_en) begin
               len_d   = len_clamp;
               busy_d  = busy_chk;
               limit_d = tmo_limit;
               data_d  = '0;
               cnt_d   = '0;
               code_d  = ERR_NONE;
               tmo_d   = '0;
               cyc_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cyc_q == CYC_W'(PRE_WAIT - 1)) begin
               cyc_d   = '0;
               state_d = S_START;
            end else begin
               cyc_d = CYC_W'(cyc_q + 1'b1);
            end
         end
         S_START: begin
            if (xfer && !resp[7]) begin
               data_d[7:0] = resp;
               cnt_d       = 3'd1;
               tmo_d       = '0;
               cyc_d       = '0;
               state_d     = (len_q > 3'd1) ? S_COLLECT : after_data;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_hit) begin
                  code_d  = ERR_START;
                  state_d = S_ERR;
               end
            end
         end
         S_COLLECT: begin
            if (xfer) begin
               for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                  if (cnt_q == 3'(i)) begin
                     data_d[8*i +: 8] = resp;
                  end
               end
               cnt_d = 3'(cnt_q + 3'd1);
               if (3'(cnt_q + 3'd1) == len_q) begin
                  tmo_d   = '0;
                  cyc_d   = '0;
                  state_d = after_data;
               end
            end
         end
         S_BUSY: begin
            if (xfer && (resp != 8'h00)) begin
               cyc_d   = '0;
               state_d = S_HOLD;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_hit) begin
                  code_d  = ERR_BUSY;
                  state_d = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (cyc_q == CYC_W'(HOLD_CYC - 1)) begin
               cyc_d = '0;
               if (data_q[6:1] != 6'd0) begin
                  code_d  = ERR_STAT;
                  state_d = S_ERR;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cyc_d = CYC_W'(cyc_q + 1'b1);
            end
         end
         S_DONE, S_ERR: begin
            if (l3_cmd_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Soft clear overrides everything, including an arm in the same cycle
      if (pin_l2_clr) begin
         state_d = S_IDLE;
         data_d  = data_q;
         cnt_d   = cnt_q;
         code_d  = ERR_NONE;
         tmo_d   = '0;
         cyc_d   = '0;
      end
   end

   // State, datapath and registered outputs derived from next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         code_q  <= ERR_NONE;
         tmo_q   <= '0;
         cyc_q   <= '0;
         len_q   <= '0;
         busy_q  <= 1'b0;
         limit_q <= '0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sw0_q   <= '0;
         sw1_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         tmo_q   <= tmo_d;
         cyc_q   <= cyc_d;
         len_q   <= len_d;
         busy_q  <= busy_d;
         limit_q <= limit_d;
         rdy_q   <= (state_d == S_START) || (state_d == S_COLLECT) || (state_d == S_BUSY);
         done_q  <= (state_d == S_DONE);
         err_q   <= (state_d == S_ERR);
         sw0_q   <= {code_d, 3'b000, cnt_d};
         sw1_q   <= {data_d[7:6], data_d[5:4] | {2{state_d == S_ERR}}, data_d[3:0]};
      end
   end

   assign resp_rdy  = rdy_q;
   assign resp_data = data_q;
   assign resp_cnt  = cnt_q;
   assign resp_done = done_q;
   assign resp_err  = err_q;
   assign err_code  = code_q;
   assign sw0       = sw0_q;
   assign sw1       = sw1_q;

endmodule

// File: tb/tb_l2_resp_multi.sv
// Directed bench for l2_resp_multi with an expected-result scoreboard.
module tb_l2_resp_multi;

   localparam int unsigned MAX_BYTES = 5;
   localparam int unsigned TMO_W     = 8;
   localparam int unsigned PRE_WAIT  = 2;
   localparam int unsigned HOLD_CYC  = 8;
   localparam int unsigned DATA_W    = 8 * MAX_BYTES;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [2:0]        cnt;
      logic [1:0]        code;
      logic              done;
      logic              err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n, pin_l2_clr, l3_en, l3_cmd_done, busy_chk, resp_vld;
   logic [2:0]        resp_len;
   logic [TMO_W-1:0]  tmo_limit;
   logic [7:0]        resp;
   logic              resp_rdy, resp_done, resp_err;
   logic [DATA_W-1:0] resp_data;
   logic [2:0]        resp_cnt;
   logic [1:0]        err_code;
   logic [7:0]        sw0, sw1;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   l2_resp_multi #(
      .MAX_BYTES(MAX_BYTES), .TMO_W(TMO_W), .PRE_WAIT(PRE_WAIT), .HOLD_CYC(HOLD_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pin_l2_clr(pin_l2_clr), .l3_en(l3_en),
      .l3_cmd_done(l3_cmd_done), .resp_len(resp_len), .busy_chk(busy_chk),
      .tmo_limit(tmo_limit), .resp(resp), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
      .resp_data(resp_data), .resp_cnt(resp_cnt), .resp_done(resp_done),
      .resp_err(resp_err), .err_code(err_code), .sw0(sw0), .sw1(sw1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic [2:0] c,
                               input logic [1:0] code);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      e.code = code;
      e.done = (code == 2'b00);
      e.err  = (code != 2'b00);
      return e;
   endfunction

   // Arm and verify the turnaround before resp_rdy rises
   task automatic arm(input logic [2:0] len, input logic bsy, input logic [TMO_W-1:0] tmo);
      resp_len  = len;
      busy_chk  = bsy;
      tmo_limit = tmo;
      l3_en     = 1'b1;
      tick();
      l3_en     = 1'b0;
      for (int i = 0; i < PRE_WAIT; i++) begin
         chk("wait_rdy_low", 64'(resp_rdy), 64'h0);
         tick();
      end
      chk("rdy_first", 64'(resp_rdy), 64'h1);
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      resp     = b;
      resp_vld = 1'b1;
      while (!resp_rdy && n < 100) begin
         tick();
         n++;
      end
      chk("send_rdy", 64'(resp_rdy), 64'h1);
      tick();
      resp_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      resp_vld = 1'b0;
      repeat (n) tick();
   endtask

   // Count resp_rdy cycles while a stuck byte is offered
   task automatic stuck(input logic [7:0] b, output int n);
      n        = 0;
      resp     = b;
      resp_vld = 1'b1;
      while (resp_rdy && n < 100) begin
         tick();
         n++;
      end
      resp_vld = 1'b0;
   endtask

   // Wait for done/err, pop the scoreboard and compare, then release
   task automatic wait_end();
      exp_t       e;
      logic [7:0] x_sw0, x_sw1;
      int         n = 0;
      while (!(resp_done || resp_err) && n < 200) begin
         tick();
         n++;
      end
      chk("end_seen", 64'(resp_done | resp_err), 64'h1);
      chk("sb_nonempty", 64'(sb_q.size() > 0), 64'h1);
      if (sb_q.size() > 0) begin
         e     = sb_q.pop_front();
         x_sw0 = {e.code, 3'b000, e.cnt};
         x_sw1 = {e.data[7:6], e.data[5:4] | {2{e.err}}, e.data[3:0]};
         chk("resp_data", 64'(resp_data), 64'(e.data));
         chk("resp_cnt", 64'(resp_cnt), 64'(e.cnt));
         chk("err_code", 64'(err_code), 64'(e.code));
         chk("done_err", 64'({resp_done, resp_err}), 64'({e.done, e.err}));
         chk("sw0", 64'(sw0), 64'(x_sw0));
         chk("sw1", 64'(sw1), 64'(x_sw1));
         repeat (3) tick();
         chk("end_hold", 64'({resp_done, resp_err}), 64'({e.done, e.err}));
         l3_cmd_done = 1'b1;
         tick();
         l3_cmd_done = 1'b0;
         chk("released", 64'({resp_rdy, resp_done, resp_err}), 64'h0);
         chk("cnt_retained", 64'(resp_cnt), 64'(e.cnt));
      end
   endtask

   initial begin
      int  n;
      logic seen;
      rst_n = 1'b0; pin_l2_clr = 1'b0; l3_en = 1'b0; l3_cmd_done = 1'b0;
      resp_len = 3'd0; busy_chk = 1'b0; tmo_limit = '0; resp = 8'h00; resp_vld = 1'b0;
      repeat (3) tick();
      chk("rst_flags", 64'({resp_rdy, resp_done, resp_err}), 64'h0);
      chk("rst_data", 64'(resp_data), 64'h0);
      chk("rst_cnt_code", 64'({resp_cnt, err_code}), 64'h0);
      chk("rst_sw", 64'({sw0, sw1}), 64'h0);
      rst_n = 1'b1;
      tick();

      // Basic single byte with fillers, hold timing
      sb_q.push_back(mk(40'h01, 3'd1, 2'b00));
      arm(3'd1, 1'b0, 8'd20);
      send(8'hFF);
      send(8'hFF);
      send(8'h01);
      n = 0;
      while (!resp_done && n < 50) begin
         tick();
         n++;
      end
      chk("hold_len", 64'(n), 64'(HOLD_CYC));
      wait_end();

      // Multi-byte with valid gaps
      sb_q.push_back(mk(40'hDDCCBBAA00, 3'd5, 2'b00));
      arm(3'd5, 1'b0, 8'd0);
      send(8'h00); idle(2);
      send(8'hAA); idle(1);
      send(8'hBB);
      send(8'hCC); idle(3);
      send(8'hDD);
      wait_end();

      // Start timeout
      sb_q.push_back(mk(40'h0, 3'd0, 2'b01));
      arm(3'd1, 1'b0, 8'd4);
      stuck(8'hFF, n);
      chk("start_tmo_cycles", 64'(n), 64'h4);
      wait_end();

      // Busy polling released by a nonzero byte
      sb_q.push_back(mk(40'h00, 3'd1, 2'b00));
      arm(3'd1, 1'b1, 8'd10);
      send(8'h00);
      repeat (3) send(8'h00);
      send(8'hFF);
      wait_end();

      // Busy timeout
      sb_q.push_back(mk(40'h00, 3'd1, 2'b10));
      arm(3'd1, 1'b1, 8'd10);
      send(8'h00);
      stuck(8'h00, n);
      chk("busy_tmo_cycles", 64'(n), 64'd10);
      wait_end();

      // Status error from start byte bits
      sb_q.push_back(mk(40'h04, 3'd1, 2'b11));
      arm(3'd1, 1'b0, 8'd0);
      send(8'h04);
      wait_end();

      // Length 0 treated as 1
      sb_q.push_back(mk(40'h01, 3'd1, 2'b00));
      arm(3'd0, 1'b0, 8'd0);
      send(8'h01);
      chk("len0_rdy", 64'(resp_rdy), 64'h0);
      wait_end();

      // Length clamp to MAX_BYTES
      sb_q.push_back(mk(40'h4433221100, 3'd5, 2'b00));
      arm(3'd7, 1'b0, 8'd0);
      send(8'h00); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("clamp_rdy", 64'(resp_rdy), 64'h0);
      wait_end();

      // Soft clear during collection
      arm(3'd3, 1'b0, 8'd0);
      send(8'h00);
      send(8'hAA);
      chk("collect_rdy", 64'(resp_rdy), 64'h1);
      pin_l2_clr = 1'b1;
      tick();
      pin_l2_clr = 1'b0;
      chk("clr_flags", 64'({resp_rdy, resp_done, resp_err}), 64'h0);
      chk("clr_retain", 64'({resp_data, resp_cnt}), 64'({40'hAA00, 3'd2}));
      chk("clr_code", 64'(err_code), 64'h0);
      seen = 1'b0;
      repeat (12) begin
         tick();
         seen = seen | resp_done | resp_err | resp_rdy;
      end
      chk("clr_no_pulse", 64'(seen), 64'h0);

      // Clear together with arm leaves the block idle
      resp_len   = 3'd1;
      pin_l2_clr = 1'b1;
      l3_en      = 1'b1;
      tick();
      pin_l2_clr = 1'b0;
      l3_en      = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen = seen | resp_rdy;
      end
      chk("clr_arm_idle", 64'(seen), 64'h0);
      chk("clr_arm_cnt", 64'(resp_cnt), 64'h2);

      chk("sb_empty", 64'(sb_q.size()), 64'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
